// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Shadows the destination/source information of the instructions in EX, MEM
// and WB, and from that state drives the EX operand forwarding selects, the
// load-use stall and the taken-branch flush. A data-memory freeze holds every
// stage register in place.
module hazard_fwd_ctrl #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] i_id_rd,
   input  logic                  i_id_regwrite,
   input  logic                  i_id_memread,
   input  logic                  i_ex_branch_taken,
   input  logic                  i_dmem_stall,
   output logic [1:0]            o_fwd_a_sel,
   output logic [1:0]            o_fwd_b_sel,
   output logic                  o_stall,
   output logic                  o_flush
);

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   // Operand mux encodings: regfile, WB result, MEM ALU result.
   localparam logic [1:0] SEL_REGFILE = 2'b00;
   localparam logic [1:0] SEL_WB      = 2'b01;
   localparam logic [1:0] SEL_MEM     = 2'b10;

   // EX stage shadow registers
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [REG_ADDR_W-1:0] ex_rs1;
   logic [REG_ADDR_W-1:0] ex_rs2;
   logic                  ex_uses_rs1;
   logic                  ex_uses_rs2;
   logic                  ex_regwrite;
   logic                  ex_memread;

   // MEM stage shadow registers
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  mem_regwrite;
   logic                  mem_memread;

   // WB stage shadow registers (a load result is already valid in WB, so
   // WB needs no memread flag for forwarding purposes)
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_regwrite;

   // Derived control
   logic                  ex_insert_bubble;
   logic                  load_in_ex;
   logic                  id_needs_rs1;
   logic                  id_needs_rs2;

   // Pick the youngest in-flight producer of a source register. A load in
   // MEM cannot forward (its data is not back yet); the load-use stall
   // guarantees that case never needs a value.
   function automatic logic [1:0] pickForward(
      input logic                  uses_src,
      input logic [REG_ADDR_W-1:0] src,
      input logic                  m_regwrite,
      input logic                  m_memread,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic                  w_regwrite,
      input logic [REG_ADDR_W-1:0] w_rd
   );
      logic [1:0] sel;
      sel = SEL_REGFILE;
      if (uses_src && m_regwrite && !m_memread && (m_rd != ZERO_REG) && (m_rd == src)) begin
         sel = SEL_MEM;
      end else if (uses_src && w_regwrite && (w_rd != ZERO_REG) && (w_rd == src)) begin
         sel = SEL_WB;
      end
      return sel;
   endfunction

   // Forwarding selects depend only on stage state, so a freeze holds them too.
   always_comb begin
      o_fwd_a_sel = pickForward(ex_uses_rs1, ex_rs1, mem_regwrite, mem_memread,
                                mem_rd, wb_regwrite, wb_rd);
      o_fwd_b_sel = pickForward(ex_uses_rs2, ex_rs2, mem_regwrite, mem_memread,
                                mem_rd, wb_regwrite, wb_rd);
   end

   // Load-use detection: a load in EX whose rd is read by the ID instruction.
   always_comb begin
      load_in_ex   = ex_memread && ex_regwrite && (ex_rd != ZERO_REG);
      id_needs_rs1 = i_id_uses_rs1 && (i_id_rs1 == ex_rd);
      id_needs_rs2 = i_id_uses_rs2 && (i_id_rs2 == ex_rd);
      o_stall      = load_in_ex && i_id_valid && (id_needs_rs1 || id_needs_rs2)
                     && !i_ex_branch_taken;
   end

   // Taken branch squashes IF/ID; flush wins over stall since the consumer dies.
   always_comb begin
      o_flush          = i_ex_branch_taken && !i_rst;
      ex_insert_bubble = o_stall || o_flush || !i_id_valid;
   end

   // EX stage: take the ID instruction or a bubble, hold during a freeze.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_rd       <= ZERO_REG;
         ex_rs1      <= ZERO_REG;
         ex_rs2      <= ZERO_REG;
         ex_uses_rs1 <= 1'b0;
         ex_uses_rs2 <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
      end else if (!i_dmem_stall) begin
         if (ex_insert_bubble) begin
            ex_rd       <= ZERO_REG;
            ex_rs1      <= ZERO_REG;
            ex_rs2      <= ZERO_REG;
            ex_uses_rs1 <= 1'b0;
            ex_uses_rs2 <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
         end else begin
            ex_rd       <= i_id_rd;
            ex_rs1      <= i_id_rs1;
            ex_rs2      <= i_id_rs2;
            ex_uses_rs1 <= i_id_uses_rs1;
            ex_uses_rs2 <= i_id_uses_rs2;
            ex_regwrite <= i_id_regwrite;
            ex_memread  <= i_id_memread;
         end
      end
   end

   // MEM and WB stages: shift down the pipe unless memory freezes everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem_rd       <= ZERO_REG;
         mem_regwrite <= 1'b0;
         mem_memread  <= 1'b0;
         wb_rd        <= ZERO_REG;
         wb_regwrite  <= 1'b0;
      end else if (!i_dmem_stall) begin
         mem_rd       <= ex_rd;
         mem_regwrite <= ex_regwrite;
         mem_memread  <= ex_memread;
         wb_rd        <= mem_rd;
         wb_regwrite  <= mem_regwrite;
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl
// Directed-vector bench for the hazard/forwarding controller. Each cycle the
// ID-stage inputs are driven on the falling edge and the outputs sampled 1 ns
// later; expected values are hand-derived from the pipeline timing.
module tb_hazard_fwd_ctrl;

   logic       i_clk;
   logic       i_rst;
   logic       i_id_valid;
   logic [4:0] i_id_rs1;
   logic [4:0] i_id_rs2;
   logic       i_id_uses_rs1;
   logic       i_id_uses_rs2;
   logic [4:0] i_id_rd;
   logic       i_id_regwrite;
   logic       i_id_memread;
   logic       i_ex_branch_taken;
   logic       i_dmem_stall;
   logic [1:0] o_fwd_a_sel;
   logic [1:0] o_fwd_b_sel;
   logic       o_stall;
   logic       o_flush;

   int totalChecks = 0;
   int badChecks   = 0;

   hazard_fwd_ctrl #(.REG_ADDR_W(5)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_id_valid        (i_id_valid),
      .i_id_rs1          (i_id_rs1),
      .i_id_rs2          (i_id_rs2),
      .i_id_uses_rs1     (i_id_uses_rs1),
      .i_id_uses_rs2     (i_id_uses_rs2),
      .i_id_rd           (i_id_rd),
      .i_id_regwrite     (i_id_regwrite),
      .i_id_memread      (i_id_memread),
      .i_ex_branch_taken (i_ex_branch_taken),
      .i_dmem_stall      (i_dmem_stall),
      .o_fwd_a_sel       (o_fwd_a_sel),
      .o_fwd_b_sel       (o_fwd_b_sel),
      .o_stall           (o_stall),
      .o_flush           (o_flush)
   );

   // 10 ns core clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Keep the run bounded even if something goes badly wrong.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [1:0] actual,
                              input logic [1:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
      end
   endtask

   // Compare all four outputs against hand-computed values.
   task automatic checkAll(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic s, input logic f);
      checkOutput({tag, ".fwdA"}, o_fwd_a_sel, a);
      checkOutput({tag, ".fwdB"}, o_fwd_b_sel, b);
      checkOutput({tag, ".stall"}, {1'b0, o_stall}, {1'b0, s});
      checkOutput({tag, ".flush"}, {1'b0, o_flush}, {1'b0, f});
   endtask

   // Drive one cycle of ID-stage inputs on the falling edge, settle 1 ns.
   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic br,
                                input logic ds);
      @(negedge i_clk);
      i_id_valid        = v;
      i_id_rs1          = rs1;
      i_id_rs2          = rs2;
      i_id_uses_rs1     = u1;
      i_id_uses_rs2     = u2;
      i_id_rd           = rd;
      i_id_regwrite     = rw;
      i_id_memread      = mr;
      i_ex_branch_taken = br;
      i_dmem_stall      = ds;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic aluOp(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      applyStimulus(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic loadOp(input logic [4:0] rd, input logic [4:0] rs1);
      applyStimulus(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic drain();
      repeat (3) idleCycle();
   endtask

   // A load sitting in MEM must never have a dependent in EX.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         checkOutput("loadInMemHazard",
                     {1'b0, (dut.mem_memread && dut.mem_regwrite && (dut.mem_rd != 5'd0) &&
                             ((dut.ex_uses_rs1 && (dut.ex_rs1 == dut.mem_rd)) ||
                              (dut.ex_uses_rs2 && (dut.ex_rs2 == dut.mem_rd))))},
                     2'b00);
      end
   end

   initial begin
      i_rst             = 1'b1;
      i_id_valid        = 1'b0;
      i_id_rs1          = 5'd0;
      i_id_rs2          = 5'd0;
      i_id_uses_rs1     = 1'b0;
      i_id_uses_rs2     = 1'b0;
      i_id_rd           = 5'd0;
      i_id_regwrite     = 1'b0;
      i_id_memread      = 1'b0;
      i_ex_branch_taken = 1'b0;
      i_dmem_stall      = 1'b0;
      $display("[TB] start");

      // Reset state; flush is masked while reset is held
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_ex_branch_taken = 1'b1;
      #1;
      checkAll("rst", 2'b00, 2'b00, 1'b0, 1'b0);
      i_rst = 1'b0;
      #1;
      checkAll("rstRelease", 2'b00, 2'b00, 1'b0, 1'b1);
      drain();

      // add x5 ; sub x6,x5,x1 -> MEM forward on A
      aluOp(5'd5, 5'd1, 5'd2);
      aluOp(5'd6, 5'd5, 5'd1);
      checkAll("A.id", 2'b00, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("A.fwd", 2'b10, 2'b00, 1'b0, 1'b0);
      drain();

      // add x5 ; nop ; or x7,x1,x5 -> WB forward on B
      aluOp(5'd5, 5'd1, 5'd2);
      idleCycle();
      aluOp(5'd7, 5'd1, 5'd5);
      idleCycle();
      checkAll("B.wb", 2'b00, 2'b01, 1'b0, 1'b0);
      drain();

      // add x5 ; add x5 ; or x7,x1,x5 -> youngest (MEM) wins
      aluOp(5'd5, 5'd1, 5'd2);
      aluOp(5'd5, 5'd3, 5'd4);
      aluOp(5'd7, 5'd1, 5'd5);
      idleCycle();
      checkAll("B.prio", 2'b00, 2'b10, 1'b0, 1'b0);
      drain();

      // add x10 ; add x11 ; add x12,x10,x11 -> A from WB, B from MEM
      aluOp(5'd10, 5'd1, 5'd2);
      aluOp(5'd11, 5'd3, 5'd4);
      aluOp(5'd12, 5'd10, 5'd11);
      idleCycle();
      checkAll("mix", 2'b01, 2'b10, 1'b0, 1'b0);
      drain();

      // lw x8 ; add x9,x8,x8 -> one stall, then WB forward on both
      loadOp(5'd8, 5'd1);
      aluOp(5'd9, 5'd8, 5'd8);
      checkAll("LU.stall", 2'b00, 2'b00, 1'b1, 1'b0);
      aluOp(5'd9, 5'd8, 5'd8);
      checkAll("LU.bubble", 2'b00, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("LU.fwd", 2'b01, 2'b01, 1'b0, 1'b0);
      drain();

      // lw x8 ; add x9,x1,x8 -> stall via rs2 only
      loadOp(5'd8, 5'd1);
      aluOp(5'd9, 5'd1, 5'd8);
      checkAll("LU2.stall", 2'b00, 2'b00, 1'b1, 1'b0);
      aluOp(5'd9, 5'd1, 5'd8);
      checkAll("LU2.bubble", 2'b00, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("LU2.fwd", 2'b00, 2'b01, 1'b0, 1'b0);
      drain();

      // lw x8 ; instruction with rs fields = x8 but no reads -> no stall
      loadOp(5'd8, 5'd1);
      applyStimulus(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkAll("LU.noUse", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // lw x8 ; invalid ID slot with matching sources -> no stall
      loadOp(5'd8, 5'd1);
      applyStimulus(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkAll("LU.invalid", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // lw x8 in EX, taken branch, dependent in ID -> flush, no stall
      loadOp(5'd8, 5'd1);
      applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      checkAll("BR.load", 2'b00, 2'b00, 1'b0, 1'b1);
      idleCycle();
      checkAll("BR.loadNext", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // add x5 in EX, taken branch squashes sub x6,x5,x1 -> EX bubble
      aluOp(5'd5, 5'd1, 5'd2);
      applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      checkAll("BR.alu", 2'b00, 2'b00, 1'b0, 1'b1);
      idleCycle();
      checkAll("BR.bubble", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // x0 is never forwarded nor stalled on
      aluOp(5'd0, 5'd1, 5'd2);
      aluOp(5'd1, 5'd0, 5'd0);
      checkAll("x0.id", 2'b00, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("x0.mem", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();
      aluOp(5'd0, 5'd1, 5'd2);
      idleCycle();
      aluOp(5'd1, 5'd0, 5'd0);
      idleCycle();
      checkAll("x0.wb", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();
      loadOp(5'd0, 5'd1);
      aluOp(5'd9, 5'd0, 5'd0);
      checkAll("x0.load", 2'b00, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("x0.loadNext", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // Memory freeze for 3 edges while a MEM forward is active
      aluOp(5'd5, 5'd1, 5'd2);
      aluOp(5'd6, 5'd5, 5'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         checkAll($sformatf("DS.hold%0d", i), 2'b10, 2'b00, 1'b0, 1'b0);
      end
      idleCycle();
      checkAll("DS.release", 2'b10, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("DS.advance", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // Memory freeze during a load-use stall keeps the stall asserted
      loadOp(5'd8, 5'd1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
         checkAll($sformatf("DSLU.hold%0d", i), 2'b00, 2'b00, 1'b1, 1'b0);
      end
      aluOp(5'd9, 5'd8, 5'd8);
      checkAll("DSLU.release", 2'b00, 2'b00, 1'b1, 1'b0);
      aluOp(5'd9, 5'd8, 5'd8);
      checkAll("DSLU.bubble", 2'b00, 2'b00, 1'b0, 1'b0);
      idleCycle();
      checkAll("DSLU.fwd", 2'b01, 2'b01, 1'b0, 1'b0);
      drain();

      // Reset in the middle of a load-use stall discards it
      loadOp(5'd8, 5'd1);
      aluOp(5'd9, 5'd8, 5'd8);
      checkAll("MR.stall", 2'b00, 2'b00, 1'b1, 1'b0);
      i_rst = 1'b1;
      applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      checkAll("MR.flushMasked", 2'b00, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkAll("MR.idle", 2'b00, 2'b00, 1'b0, 1'b0);
      i_rst = 1'b0;
      idleCycle();
      checkAll("MR.after", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
